// File: rtl/rca_share_arbiter_pkg.sv
// rtl/rca_share_arbiter_pkg.sv - shared types and constants for the adder arbiter
package rca_share_arbiter_pkg;

  localparam int RCA_LAT = 16;
  localparam int RCA_W   = 16;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/pp_16_rca.sv
// rtl/pp_16_rca.sv - 16-bit ripple-carry adder pipelined one bit per stage
// Operands present at edge k give S/Cout after edge k+15 (16 register stages).
module pp_16_rca (
  input  logic        clk,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] s_o,
  output logic        cout_o
);

  localparam int W = 16;

  logic [W-1:0] a_q [W-1];
  logic [W-1:0] b_q [W-1];
  logic [W-1:0] s_q [W];
  logic         c_q [W];

  always_ff @(posedge clk) begin
    a_q[0] <= a_i;
    b_q[0] <= b_i;
    s_q[0] <= W'(a_i[0] ^ b_i[0] ^ cin_i);
    c_q[0] <= (a_i[0] & b_i[0]) | (cin_i & (a_i[0] ^ b_i[0]));
    for (int j = 1; j < W - 1; j++) begin
      a_q[j] <= a_q[j-1];
      b_q[j] <= b_q[j-1];
    end
    // Stage j resolves bit j and forwards the carry to stage j+1.
    for (int j = 1; j < W; j++) begin
      s_q[j] <= s_q[j-1] | (W'(a_q[j-1][j] ^ b_q[j-1][j] ^ c_q[j-1]) << j);
      c_q[j] <= (a_q[j-1][j] & b_q[j-1][j]) | (c_q[j-1] & (a_q[j-1][j] ^ b_q[j-1][j]));
    end
  end

  assign s_o    = s_q[W-1];
  assign cout_o = c_q[W-1];

endmodule

// File: rtl/rca_tag_pipe.sv
// rtl/rca_tag_pipe.sv - LAT-deep {valid,id} shift register tracking in-flight adds
module rca_tag_pipe
  import rca_share_arbiter_pkg::*;
#(
  parameter int LAT = RCA_LAT
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t stage_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/rca_share_arbiter.sv
// rtl/rca_share_arbiter.sv - round-robin sharing of pp_16_rca between two requesters
// LAT must match the pp_16_rca depth so the tag and the sum leave together.
module rca_share_arbiter
  import rca_share_arbiter_pkg::*;
#(
  parameter  int LAT     = RCA_LAT,
  parameter  int MAX_OUT = 8,
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [RCA_W-1:0] req0_a,
  input  logic [RCA_W-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [RCA_W-1:0] req1_a,
  input  logic [RCA_W-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp0_valid,
  output logic [RCA_W-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  output logic [RCA_W-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic [CW-1:0]    out0_cnt,
  output logic [CW-1:0]    out1_cnt
);

  logic             last_grant_q, last_grant_d;
  logic             elig0, elig1, grant0, grant1, xfer;
  req_id_t          grant_id;
  logic [RCA_W-1:0] add_a, add_b, add_s;
  logic             add_cin, add_cout;
  tag_t             tag_in, tag_out;
  logic             hit0, hit1;
  logic [CW-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [RCA_W-1:0] rsp0_sum_q, rsp0_sum_d, rsp1_sum_q, rsp1_sum_d;
  logic             rsp0_cout_q, rsp0_cout_d, rsp1_cout_q, rsp1_cout_d;

  assign elig0 = req0_valid && (cnt0_q < CW'(MAX_OUT));
  assign elig1 = req1_valid && (cnt1_q < CW'(MAX_OUT));

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign xfer       = grant0 | grant1;
  assign grant_id   = grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (grant0) begin
      add_a   = req0_a;
      add_b   = req0_b;
      add_cin = req0_cin;
    end else if (grant1) begin
      add_a   = req1_a;
      add_b   = req1_b;
      add_cin = req1_cin;
    end
  end

  pp_16_rca u_rca (
    .clk    (clk),
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .s_o    (add_s),
    .cout_o (add_cout)
  );

  assign tag_in = {xfer, grant_id};

  rca_tag_pipe #(.LAT(LAT)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign hit0 = tag_out.valid && (tag_out.id == 1'b0);
  assign hit1 = tag_out.valid && (tag_out.id == 1'b1);

  always_comb begin
    last_grant_d = xfer ? grant_id : last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (grant0 && !hit0) cnt0_d = cnt0_q + 1'b1;
    else if (!grant0 && hit0) cnt0_d = cnt0_q - 1'b1;
    if (grant1 && !hit1) cnt1_d = cnt1_q + 1'b1;
    else if (!grant1 && hit1) cnt1_d = cnt1_q - 1'b1;
    rsp0_valid_d = hit0;
    rsp1_valid_d = hit1;
    rsp0_sum_d   = hit0 ? add_s : rsp0_sum_q;
    rsp0_cout_d  = hit0 ? add_cout : rsp0_cout_q;
    rsp1_sum_d   = hit1 ? add_s : rsp1_sum_q;
    rsp1_cout_d  = hit1 ? add_cout : rsp1_cout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_sum_q   <= '0;
      rsp1_sum_q   <= '0;
      rsp0_cout_q  <= 1'b0;
      rsp1_cout_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_sum_q   <= rsp0_sum_d;
      rsp1_sum_q   <= rsp1_sum_d;
      rsp0_cout_q  <= rsp0_cout_d;
      rsp1_cout_q  <= rsp1_cout_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_sum   = rsp0_sum_q;
  assign rsp1_sum   = rsp1_sum_q;
  assign rsp0_cout  = rsp0_cout_q;
  assign rsp1_cout  = rsp1_cout_q;
  assign out0_cnt   = cnt0_q;
  assign out1_cnt   = cnt1_q;

endmodule
